// File: rtl/ltc2311_pkg.sv
// Shared definitions for the LTC2311 emulator and the matching reader.
// Contents: emulator state encoding, default result width and default
// conversion time in system clocks.
package ltc2311_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    READY   = 2'd2,
    SHIFT   = 2'd3
  } emu_state_t;

  localparam int LTC2311_DATA_WIDTH  = 16;
  localparam int LTC2311_CONV_CYCLES = 8;

endpackage

// File: rtl/ltc2311_emulator_if.sv
// Serial bus between an LTC2311 reader (master) and the device or its
// emulator (slave).
//   cnv_n : conversion strobe, rise starts a conversion, low enables readout
//   sck   : serial clock, idles high
//   sdo   : serial data from the device, MSB first
interface ltc2311_emulator_if;
  logic cnv_n;
  logic sck;
  logic sdo;

  modport master (output cnv_n, output sck, input sdo);
  modport slave  (input cnv_n, input sck, output sdo);
endinterface

// File: rtl/sync_edge_detect.sv
// Oversampling input synchronizer with edge detection.
// Parameters: SYNC_STAGES (>= 2) flops in the chain, RESET_VAL for the value
// the chain and history flop hold out of reset.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   i_async    : asynchronous input pin
//   o_level    : synchronized level
//   o_rise     : one-cycle high on a synchronized 0->1 transition
//   o_fall     : one-cycle high on a synchronized 1->0 transition
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_hist <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/ltc2311_emulator.sv
// Device-side model of the LTC2311 serial interface. cnv_n and sck are
// oversampled on clk; a rising cnv_n captures sample_in, and after the
// conversion time the held value is shifted out MSB first on sdo, one bit
// per sck fall.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   sample_in      : value to report, captured at conversion start
//   sample_taken   : one-cycle pulse when sample_in is captured
//   conv_busy      : high while a conversion is in progress
//   frame_done     : one-cycle pulse after the last bit has been shifted
//   err_early_read : one-cycle pulse when cnv_n falls before conversion ends
//   err_extra_sck  : one-cycle pulse on an sck fall outside SHIFT
//   bus            : cnv_n / sck in, sdo out
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a cnv_n rise, sdo low
// CONVERT | conversion running, conv_busy high, conv_cnt counting
// READY   | result held, waiting for cnv_n to fall
// SHIFT   | shifting shift_reg out on sdo, one bit per sck fall
module ltc2311_emulator
  import ltc2311_pkg::*;
#(
  parameter int DATA_WIDTH  = LTC2311_DATA_WIDTH,
  parameter int CONV_CYCLES = LTC2311_CONV_CYCLES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic                  sample_taken,
  output logic                  conv_busy,
  output logic                  frame_done,
  output logic                  err_early_read,
  output logic                  err_extra_sck,
  ltc2311_emulator_if.slave     bus
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  logic w_cnv_level, w_cnv_rise, w_cnv_fall;
  // sdo only moves on sck falls, so the sck level and rise are not needed.
  logic w_sck_level_unused, w_sck_rise_unused, w_sck_fall;

  emu_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_conv_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_sdo;
  logic                  r_sample_taken;
  logic                  r_conv_busy;
  logic                  r_frame_done;
  logic                  r_err_early;
  logic                  r_err_extra;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_cnv_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.cnv_n),
    .o_level (w_cnv_level),
    .o_rise  (w_cnv_rise),
    .o_fall  (w_cnv_fall)
  );

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sck_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.sck),
    .o_level (w_sck_level_unused),
    .o_rise  (w_sck_rise_unused),
    .o_fall  (w_sck_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_hold         <= '0;
      r_shift        <= '0;
      r_conv_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_sdo          <= 1'b0;
      r_sample_taken <= 1'b0;
      r_conv_busy    <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_early    <= 1'b0;
      r_err_extra    <= 1'b0;
    end else begin
      r_sample_taken <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_early    <= 1'b0;
      r_err_extra    <= w_sck_fall && (r_state != SHIFT);

      // A cnv rise restarts from any state; in SHIFT it also beats a
      // coincident sck fall and discards the unsent bits.
      if (w_cnv_rise) begin
        r_hold         <= sample_in;
        r_sample_taken <= 1'b1;
        r_conv_cnt     <= '0;
        r_bit_cnt      <= '0;
        r_sdo          <= 1'b0;
        r_conv_busy    <= 1'b1;
        r_state        <= CONVERT;
      end else begin
        case (r_state)
          IDLE: begin
            r_sdo       <= 1'b0;
            r_conv_busy <= 1'b0;
          end
          CONVERT: begin
            if (w_cnv_fall) begin
              r_conv_busy <= 1'b0;
              if (r_conv_cnt == CONV_LAST) begin
                // Fall on the completing cycle still counts as in time.
                r_shift   <= r_hold;
                r_sdo     <= r_hold[DATA_WIDTH-1];
                r_bit_cnt <= '0;
                r_state   <= SHIFT;
              end else begin
                r_err_early <= 1'b1;
                r_sdo       <= 1'b0;
                r_state     <= IDLE;
              end
            end else if (r_conv_cnt == CONV_LAST) begin
              r_conv_busy <= 1'b0;
              r_state     <= READY;
            end else begin
              r_conv_cnt <= r_conv_cnt + 1'b1;
            end
          end
          READY: begin
            r_sdo       <= 1'b0;
            r_conv_busy <= 1'b0;
            if (w_cnv_fall) begin
              r_shift   <= r_hold;
              r_sdo     <= r_hold[DATA_WIDTH-1];
              r_bit_cnt <= '0;
              r_state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (w_sck_fall && !w_cnv_level) begin
              r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BIT_LAST) begin
                r_sdo        <= 1'b0;
                r_frame_done <= 1'b1;
                r_state      <= IDLE;
              end else begin
                r_sdo <= r_shift[DATA_WIDTH-2];
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sdo        = r_sdo;
  assign sample_taken   = r_sample_taken;
  assign conv_busy      = r_conv_busy;
  assign frame_done     = r_frame_done;
  assign err_early_read = r_err_early;
  assign err_extra_sck  = r_err_extra;

endmodule
